// File: rtl/gnrl_bitstr_pkg.sv
// Shared types and defaults for the bitstream sequencer.
package gnrl_bitstr_pkg;

   localparam int DEF_BUS_WIDTH = 32;
   localparam int DEF_CNT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIRST = 2'd1,
      RUN   = 2'd2
   } state_t;

   // Position of the valid/terminator flag in a FIFO word.
   function automatic int valid_bit(input int bus_width);
      return bus_width - 1;
   endfunction

endpackage

// File: rtl/gnrl_bitstr_down_cnt.sv
// Loadable down-counter; stops at zero and reports it on a zero flag.
module gnrl_bitstr_down_cnt
   import gnrl_bitstr_pkg::*;
#(
   parameter int WIDTH = DEF_CNT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   localparam logic [WIDTH-1:0] ONE = 1;

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/gnrl_bitstr_cnt.sv
// Bitstream sequencer: plays timed words from a show-ahead FIFO for N+1 cycles each.
// GNRL_BITSTR_STICKY_DEND_EN makes D_END a level cleared by the next accepted START.
module gnrl_bitstr_cnt
   import gnrl_bitstr_pkg::*;
#(
   parameter int BUS_WIDTH = DEF_BUS_WIDTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic                 STOP,
   output logic                 READY,
   input  logic [BUS_WIDTH-1:0] bitstr_in,
   output logic [BUS_WIDTH-1:0] bitstr_out,
   output logic                 D_END
);

   localparam int VB = valid_bit(BUS_WIDTH);

   state_t                 state_q, state_d;
   logic [BUS_WIDTH-1:0]   out_q, out_d;
   logic                   dend_q, dend_d;
   logic                   word_valid;
   logic                   cnt_zero;
   logic                   cnt_load;
   logic                   cnt_en;
   logic [CNT_WIDTH-1:0]   cnt_val;
   logic                   capture;
   logic                   end_set;

   assign word_valid = bitstr_in[VB];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         out_q   <= '0;
         dend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         dend_q  <= dend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (STOP) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (START) state_d = FIRST;
            FIRST:   state_d = word_valid ? RUN : IDLE;
            RUN:     if (cnt_zero && !word_valid) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // STOP blocks the FIFO read so an aborted sequence never consumes a word.
   always_comb begin
      capture  = !STOP && ((state_q == FIRST) || ((state_q == RUN) && cnt_zero));
      out_d    = out_q;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      cnt_val  = bitstr_in[CNT_WIDTH-1:0];
      end_set  = 1'b0;
      if (STOP) begin
         out_d    = '0;
         cnt_load = 1'b1;
         cnt_val  = '0;
         end_set  = 1'b1;
      end else if (capture) begin
         if (word_valid) begin
            out_d    = bitstr_in;
            cnt_load = 1'b1;
         end else begin
            out_d   = '0;
            end_set = 1'b1;
         end
      end else if (state_q == RUN) begin
         cnt_en = 1'b1;
      end
`ifdef GNRL_BITSTR_STICKY_DEND_EN
      if (end_set) begin
         dend_d = 1'b1;
      end else if ((state_q == IDLE) && START) begin
         dend_d = 1'b0;
      end else begin
         dend_d = dend_q;
      end
`else
      dend_d = end_set;
`endif
   end

   gnrl_bitstr_down_cnt #(
      .WIDTH (CNT_WIDTH)
   ) u_down_cnt (
      .clk      (CLK),
      .rst_n    (RST),
      .load     (cnt_load),
      .en       (cnt_en),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   assign READY      = capture;
   assign bitstr_out = out_q;
   assign D_END      = dend_q;

endmodule

// File: tb/tb_gnrl_bitstr_cnt.sv
// Directed bench for gnrl_bitstr_cnt with a FIFO model and a per-cycle expectation scoreboard.
module tb_gnrl_bitstr_cnt;

`ifdef GNRL_BITSTR_STICKY_DEND_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   typedef struct {
      logic [31:0] out;
      logic        dend;
      logic        ready;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic        STOP;
   logic        READY;
   logic [31:0] bitstr_in;
   logic [31:0] bitstr_out;
   logic        D_END;

   logic [31:0] fifo[$];
   logic [31:0] stim[$];
   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          rd_cnt = 0;

   gnrl_bitstr_cnt #(.BUS_WIDTH(32), .CNT_WIDTH(16)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .START      (START),
      .STOP       (STOP),
      .READY      (READY),
      .bitstr_in  (bitstr_in),
      .bitstr_out (bitstr_out),
      .D_END      (D_END)
   );

   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic refresh_head();
      bitstr_in = (fifo.size() > 0) ? fifo[0] : 32'h0;
   endtask

   // Called at a falling edge; advances to the next falling edge, modelling FIFO pops.
   task automatic step();
      bit consume;
      #1;
      consume = READY;
      if (consume) rd_cnt++;
      @(posedge CLK);
      #1;
      if (consume && (fifo.size() > 0)) void'(fifo.pop_front());
      refresh_head();
      @(negedge CLK);
   endtask

   // Expected per-cycle outputs from the FIRST cycle onward, derived from the word list.
   task automatic expect_seq();
      int n;
      sb.push_back('{32'h0, 1'b0, 1'b1});
      foreach (stim[i]) begin
         if (stim[i][31]) begin
            n = int'(stim[i][15:0]);
            for (int k = 0; k <= n; k++) sb.push_back('{stim[i], 1'b0, (k == n)});
         end else begin
            sb.push_back('{32'h0, 1'b1, 1'b0});
            sb.push_back('{32'h0, STICKY, 1'b0});
            break;
         end
      end
   endtask

   task automatic start_seq();
      fifo = stim;
      refresh_head();
      expect_seq();
      START = 1'b1;
      step();
      START = 1'b0;
   endtask

   task automatic run_sb(input int cycles, input string name);
      exp_t e;
      for (int i = 0; i < cycles; i++) begin
         e = sb.pop_front();
         #1;
         chk($sformatf("%s.c%0d.out", name, i), bitstr_out, e.out);
         chk($sformatf("%s.c%0d.dend", name, i), {31'h0, D_END}, {31'h0, e.dend});
         chk($sformatf("%s.c%0d.ready", name, i), {31'h0, READY}, {31'h0, e.ready});
         step();
      end
   endtask

   initial begin
      int rd0;
      int fsz;
      RST = 1'b0; START = 1'b0; STOP = 1'b0; bitstr_in = 32'h0;

      // Reset holds outputs at zero whatever the inputs do
      @(negedge CLK);
      for (int i = 0; i < 6; i++) begin
         START = 1'($urandom_range(0, 1));
         STOP = 1'($urandom_range(0, 1));
         bitstr_in = $urandom;
         #1;
         chk($sformatf("rst%0d.ready", i), {31'h0, READY}, 32'h0);
         chk($sformatf("rst%0d.out", i), bitstr_out, 32'h0);
         chk($sformatf("rst%0d.dend", i), {31'h0, D_END}, 32'h0);
         @(negedge CLK);
      end
      START = 1'b0; STOP = 1'b0; bitstr_in = 32'h0;
      RST = 1'b1;
      step();

      // Single word held N+1=4 cycles, then terminator
      stim = '{32'h8000_0003, 32'h0000_0000};
      start_seq();
      run_sb(sb.size(), "single");

      // Back-to-back words without idle gap
      stim = '{32'h8000_0000, 32'h8000_0002, 32'h8000_0001, 32'h0000_0000};
      rd0 = rd_cnt;
      start_seq();
      run_sb(sb.size(), "b2b");
      chk("b2b.reads", rd_cnt - rd0, 4);

      // Abort during a long random stream
      stim.delete();
      for (int i = 0; i < 120; i++) stim.push_back(32'h8000_0000 + $urandom_range(0, 9));
      start_seq();
      run_sb(99, "abort");
      sb.delete();
      STOP = 1'b1;
      #1;
      chk("abort.ready_in_stop", {31'h0, READY}, 32'h0);
      fsz = fifo.size();
      rd0 = rd_cnt;
      step();
      chk("abort.out", bitstr_out, 32'h0);
      chk("abort.dend", {31'h0, D_END}, 32'h1);
      for (int i = 0; i < 6; i++) begin
         if (i == 3) STOP = 1'b0;
         #1;
         chk($sformatf("abort.idle%0d.ready", i), {31'h0, READY}, 32'h0);
         step();
      end
      chk("abort.no_reads", rd_cnt - rd0, 0);
      chk("abort.fifo_level", fifo.size(), fsz);
      fifo.delete();
      refresh_head();

      // START and STOP together in IDLE
      stim = '{32'h8000_0005, 32'h0000_0000};
      fifo = stim;
      refresh_head();
      rd0 = rd_cnt;
      START = 1'b1; STOP = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("ss%0d.ready", i), {31'h0, READY}, 32'h0);
         chk($sformatf("ss%0d.out", i), bitstr_out, 32'h0);
         step();
      end
      START = 1'b0; STOP = 1'b0;
      step();
      chk("ss.no_reads", rd_cnt - rd0, 0);
      fifo.delete();
      refresh_head();

      // Reset mid-sequence returns to reset values with no D_END
      stim = '{32'h8000_0009, 32'h0000_0000};
      start_seq();
      step();
      step();
      chk("midrst.before", bitstr_out, 32'h8000_0009);
      sb.delete();
      RST = 1'b0;
      #1;
      chk("midrst.out", bitstr_out, 32'h0);
      chk("midrst.ready", {31'h0, READY}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) RST = 1'b1;
         step();
         chk($sformatf("midrst%0d.dend", i), {31'h0, D_END}, 32'h0);
         chk($sformatf("midrst%0d.out", i), bitstr_out, 32'h0);
      end
      fifo.delete();
      refresh_head();

      // A sequence after reset still plays correctly (terminator first)
      stim = '{32'h0000_0000};
      start_seq();
      run_sb(sb.size(), "termonly");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gnrl_bitstr_cnt.md
Name: gnrl_bitstr_cnt

Overview:
- Bitstream sequencer: pulls timed words from a show-ahead FIFO and drives each word on its output for a programmed number of clock cycles.
- Sits between the SoC-loaded bitstream FIFO and the pulse/gate logic.
- Started and aborted by SoC strobes; reports end of sequence to the SoC on D_END.

Parameters:
- BUS_WIDTH, 32, width of FIFO word and output bus.
- CNT_WIDTH, 16, width of hold-count field in bits [CNT_WIDTH-1:0]; must be < BUS_WIDTH-1.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  start strobe from SoC (level sampled per cycle).
- STOP  in  1  abort strobe from SoC.
- READY  out  1  FIFO read-acknowledge: word on bitstr_in is consumed in every cycle READY=1.
- bitstr_in  in  BUS_WIDTH  FIFO head word (show-ahead, valid without request).
- bitstr_out  out  BUS_WIDTH  currently active word.
- D_END  out  1  end-of-sequence indication.

Behaviour:
- Word format: bit [BUS_WIDTH-1] = valid; 1 = timed word, 0 = terminator.
- Word format: bits [CNT_WIDTH-1:0] = hold count N. The word is driven for N+1 cycles.
- Reset (RST=0, async): state IDLE, bitstr_out=0, D_END=0, counter=0. READY=0 while in reset.
- States: IDLE, FIRST, RUN.
- IDLE: READY=0, bitstr_out=0. START=1 and STOP=0 -> FIRST.
- FIRST (one cycle): READY=1; the word is captured at the clock edge.
  - Valid word: bitstr_out<=word, counter<=N, -> RUN.
  - Terminator: D_END pulse, -> IDLE.
- RUN: READY is combinational, = (counter==0).
  - counter!=0: counter decrements, bitstr_out is held.
  - counter==0: the next word is captured on the same edge, giving gap-free back-to-back words. Valid word: reload bitstr_out and counter. Terminator: bitstr_out<=0, D_END pulse, -> IDLE.
- Latency: the first word appears on bitstr_out 2 edges after START is sampled high.
- STOP=1 in any state:
  - Next edge: -> IDLE, bitstr_out<=0, counter<=0, READY=0 in that cycle (no word consumed), D_END pulse.
  - STOP has priority over START and over word capture in the same cycle.
- START while in FIRST or RUN: ignored.
- START held high across IDLE re-entry: restarts the sequence (level sensitive).
- D_END default: registered one-cycle pulse, asserted in the cycle after the terminator capture or the STOP cycle.
- N=0: word is held 1 cycle, and READY stays high continuously for consecutive N=0 words.
- Max N = 2^CNT_WIDTH-1; no overflow possible. Counter only decrements while in RUN and counter!=0.
- Reset asserted mid-sequence: immediate return to reset values; no D_END is produced.

Optional Feature:
- Macro: GNRL_BITSTR_STICKY_DEND_EN.
- Defined: D_END is a level. It sets on terminator or STOP and clears when the next START is accepted or on reset.
- Undefined: D_END is a one-cycle pulse, as described in Behaviour.

Decomposition:
- Package gnrl_bitstr_pkg holds:
  - state enum (IDLE/FIRST/RUN);
  - default BUS_WIDTH/CNT_WIDTH constants;
  - VALID_BIT index helper.
- Sub-module gnrl_bitstr_down_cnt: loadable down-counter with load, en, zero flag.
- FSM and output register stay in the top module.

Test Plan:
- Reset: RST=0 with random inputs -> READY=0, bitstr_out=0, D_END=0; holds until RST=1.
- Single word: FIFO = {0x8000_0003, 0x0000_0000}, pulse START -> bitstr_out=0x8000_0003 for exactly 4 cycles, READY high 1 cycle before and at the word's last cycle, then bitstr_out=0 and D_END pulse 1 cycle.
- Back-to-back: words 0x8000_0000, 0x8000_0002, 0x8000_0001, terminator -> outputs held 1, 3 and 2 cycles with no idle gap; READY count = 4.
- Abort: continuous random words (0x8000_0000 + 0..9), STOP=1 after 100 cycles -> next edge bitstr_out=0, D_END pulse, READY=0, no further reads while STOP or idle.
- Simultaneous START and STOP in IDLE -> stays IDLE, READY never asserted.
- Sticky variant (macro defined): after terminator, D_END stays 1 until the next START, then 0 in the FIRST cycle.
